// File: rtl/rx_block_sync.sv
// 64b/66b block-lock stage between the RX gearbox and the descrambler.
// Hunts for header alignment via bitslip, then monitors header quality.
`timescale 1ns/1ps
module rx_block_sync #(
    parameter int RX_DATA_WIDTH = 64,
    parameter int LOCK_COUNT    = 64,
    parameter int WINDOW        = 1024,
    parameter int BAD_LIMIT     = 16,
    parameter int SLIP_WAIT     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [0:RX_DATA_WIDTH+1] data_in,
    input  logic                     data_in_valid,
    output logic [0:RX_DATA_WIDTH+1] data_out,
    output logic                     data_out_valid,
    output logic                     slip,
    output logic                     locked,
    output logic [15:0]              bad_hdr_cnt
);

    localparam int GW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(WINDOW) + 1;
    localparam int BW = $clog2(BAD_LIMIT) + 1;
    localparam int SW = $clog2(SLIP_WAIT) + 1;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_LOCKED
    } state_t;

    state_t        state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [SW-1:0] wait_cnt, wait_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [BW-1:0] bad_cnt, bad_n;
    logic [15:0]   bhc_n;
    logic          slip_n;
    logic          locked_n;
    logic          hdr_ok;

    // Only 01 and 10 are legal sync headers.
    assign hdr_ok = data_in[0] ^ data_in[1];

    always_comb begin
        state_n  = state;
        good_n   = good_cnt;
        wait_n   = wait_cnt;
        win_n    = win_cnt;
        bad_n    = bad_cnt;
        bhc_n    = bad_hdr_cnt;
        slip_n   = 1'b0;
        locked_n = locked;
        if (data_in_valid) begin
            unique case (state)
                ST_HUNT: begin
                    if (hdr_ok) begin
                        if (good_cnt == GW'(LOCK_COUNT - 1)) begin
                            state_n  = ST_LOCKED;
                            locked_n = 1'b1;
                            good_n   = '0;
                            win_n    = '0;
                            bad_n    = '0;
                        end else begin
                            good_n = good_cnt + 1'b1;
                        end
                    end else begin
                        slip_n  = 1'b1;
                        good_n  = '0;
                        wait_n  = SW'(SLIP_WAIT - 1);
                        state_n = ST_SLIP_WAIT;
                    end
                end
                ST_SLIP_WAIT: begin
                    if (wait_cnt == '0) begin
                        state_n = ST_HUNT;
                        good_n  = '0;
                    end else begin
                        wait_n = wait_cnt - 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!hdr_ok && bad_hdr_cnt != 16'hFFFF)
                        bhc_n = bad_hdr_cnt + 16'd1;
                    // Loss of lock wins over the window boundary.
                    if (!hdr_ok && bad_cnt == BW'(BAD_LIMIT - 1)) begin
                        locked_n = 1'b0;
                        slip_n   = 1'b1;
                        good_n   = '0;
                        wait_n   = SW'(SLIP_WAIT - 1);
                        state_n  = ST_SLIP_WAIT;
                    end else if (win_cnt == WW'(WINDOW - 1)) begin
                        win_n = '0;
                        bad_n = '0;
                    end else begin
                        win_n = win_cnt + 1'b1;
                        if (!hdr_ok)
                            bad_n = bad_cnt + 1'b1;
                    end
                end
                default: state_n = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_HUNT;
            good_cnt       <= '0;
            wait_cnt       <= '0;
            win_cnt        <= '0;
            bad_cnt        <= '0;
            bad_hdr_cnt    <= '0;
            slip           <= 1'b0;
            locked         <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state          <= state_n;
            good_cnt       <= good_n;
            wait_cnt       <= wait_n;
            win_cnt        <= win_n;
            bad_cnt        <= bad_n;
            bad_hdr_cnt    <= bhc_n;
            slip           <= slip_n;
            locked         <= locked_n;
            data_out_valid <= data_in_valid & locked_n;
            if (data_in_valid)
                data_out <= data_in;
        end
    end

endmodule

// File: tb/tb_rx_block_sync.sv
// Randomized bench for rx_block_sync against a word-level lock model.
// Model tracks run lengths and window positions rather than FSM states.
`timescale 1ns/1ps
module tb_rx_block_sync;

    logic        clk;
    logic        rst_n;
    logic [0:65] data_in;
    logic        data_in_valid;
    logic [0:65] data_out;
    logic        data_out_valid;
    logic        slip;
    logic        locked;
    logic [15:0] bad_hdr_cnt;

    int total = 0;
    int bad   = 0;

    bit          m_locked, m_slip, m_dov;
    int          m_run, m_ignore, m_wpos, m_wbad, m_bhc;
    logic [0:65] m_dout;

    rx_block_sync dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .slip           (slip),
        .locked         (locked),
        .bad_hdr_cnt    (bad_hdr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic m_reset();
        m_locked = 0; m_slip = 0; m_dov = 0;
        m_run = 0; m_ignore = 0; m_wpos = 0; m_wbad = 0; m_bhc = 0;
        m_dout = '0;
    endtask

    // Drive one cycle and advance the reference model by one word.
    task automatic step(input logic [1:0] h, input bit v);
        logic [63:0] pl;
        bit ok;
        pl = {$urandom, $urandom};
        data_in = {h, pl};
        data_in_valid = v;
        m_slip = 0;
        m_dov = 0;
        if (v) begin
            ok = (h == 2'b01) || (h == 2'b10);
            m_dout = data_in;
            if (m_ignore > 0) begin
                m_ignore--;
            end else if (!m_locked) begin
                if (ok) begin
                    m_run++;
                    if (m_run == 64) begin
                        m_locked = 1; m_run = 0; m_wpos = 0; m_wbad = 0;
                    end
                end else begin
                    m_slip = 1; m_run = 0; m_ignore = 32;
                end
            end else begin
                if (!ok) begin
                    if (m_bhc < 65535) m_bhc++;
                    m_wbad++;
                end
                if (!ok && m_wbad == 16) begin
                    m_locked = 0; m_slip = 1; m_ignore = 32; m_run = 0;
                end else begin
                    m_wpos++;
                    if (m_wpos == 1024) begin
                        m_wpos = 0; m_wbad = 0;
                    end
                end
            end
            m_dov = m_locked;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        data_in_valid = 1'b0;
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({locked, slip, data_out_valid} !== 3'b000 ||
            bad_hdr_cnt !== 16'd0 || data_out !== 66'd0) begin
            bad++;
            $display("FAIL reset lk=%b sl=%b dv=%b bhc=%0d dout=%h want all 0",
                     locked, slip, data_out_valid, bad_hdr_cnt, data_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_acquire();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step(2'b01, 1'b1);
            total++;
            if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                bad_hdr_cnt !== 16'(m_bhc) || data_out !== m_dout) begin
                bad++;
                $display("FAIL acquire i=%0d lk=%b/%b sl=%b/%b dv=%b/%b dout=%h/%h",
                         i, locked, m_locked, slip, m_slip, data_out_valid, m_dov,
                         data_out, m_dout);
            end
        end
        total++;
        if ({locked, data_out_valid} !== 2'b11) begin
            bad++;
            $display("FAIL acquire_end lk=%b dv=%b want 1 1", locked, data_out_valid);
        end
    endtask

    task automatic test_slip_hunt();
        logic [1:0] h;
        do_reset();
        for (int i = 0; i < 10 + 1 + 32 + 64; i++) begin
            if (i < 10) h = good_hdr();
            else if (i == 10) h = 2'b11;
            else if (i < 43) h = 2'($urandom_range(0, 3));
            else h = good_hdr();
            step(h, 1'b1);
            total++;
            if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                bad_hdr_cnt !== 16'(m_bhc) || data_out !== m_dout) begin
                bad++;
                $display("FAIL slip_hunt i=%0d lk=%b/%b sl=%b/%b dv=%b/%b",
                         i, locked, m_locked, slip, m_slip, data_out_valid, m_dov);
            end
            if (i == 10) begin
                total++;
                if (slip !== 1'b1) begin
                    bad++;
                    $display("FAIL slip_pulse slip=%b want 1", slip);
                end
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL slip_relock lk=%b want 1", locked);
        end
    endtask

    task automatic test_window();
        logic [1:0] h;
        do_reset();
        for (int i = 0; i < 64; i++) step(good_hdr(), 1'b1);
        for (int w = 0; w < 3; w++) begin
            for (int p = 0; p < 1024; p++) begin
                if (w != 1) h = (p % 64 == 10 && p < 15 * 64) ? 2'b00 : good_hdr();
                else h = ((p % 64 == 20 && p < 14 * 64) || p == 1023) ? 2'b00 : good_hdr();
                step(h, 1'b1);
                total++;
                if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                    bad_hdr_cnt !== 16'(m_bhc) || data_out !== m_dout) begin
                    bad++;
                    $display("FAIL window w=%0d p=%0d lk=%b/%b sl=%b/%b dv=%b/%b bhc=%0d/%0d",
                             w, p, locked, m_locked, slip, m_slip, data_out_valid, m_dov,
                             bad_hdr_cnt, m_bhc);
                end
            end
            if (w == 0) begin
                total++;
                if (bad_hdr_cnt !== 16'd15 || locked !== 1'b1) begin
                    bad++;
                    $display("FAIL window15 bhc=%0d lk=%b want 15 1", bad_hdr_cnt, locked);
                end
            end
        end
        total++;
        if (bad_hdr_cnt !== 16'd45 || locked !== 1'b1) begin
            bad++;
            $display("FAIL window_end bhc=%0d lk=%b want 45 1", bad_hdr_cnt, locked);
        end
    endtask

    task automatic test_lose_lock();
        logic [1:0] h;
        int nbad;
        do_reset();
        for (int i = 0; i < 164; i++) step(good_hdr(), 1'b1);
        nbad = 0;
        for (int i = 0; i < 80 + 32 + 64; i++) begin
            if (i < 80) h = (i % 5 == 4) ? 2'b00 : good_hdr();
            else if (i < 112) h = 2'($urandom_range(0, 3));
            else h = good_hdr();
            step(h, 1'b1);
            if (i < 80 && h == 2'b00) nbad++;
            total++;
            if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                bad_hdr_cnt !== 16'(m_bhc) || data_out !== m_dout) begin
                bad++;
                $display("FAIL lose i=%0d lk=%b/%b sl=%b/%b dv=%b/%b bhc=%0d/%0d",
                         i, locked, m_locked, slip, m_slip, data_out_valid, m_dov,
                         bad_hdr_cnt, m_bhc);
            end
            if (i == 79) begin
                total++;
                if ({locked, slip, data_out_valid} !== 3'b010 || nbad != 16) begin
                    bad++;
                    $display("FAIL lose_16th lk=%b sl=%b dv=%b want 0 1 0",
                             locked, slip, data_out_valid);
                end
            end
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL lose_relock lk=%b want 1", locked);
        end
    endtask

    task automatic test_gaps();
        int nvalid;
        int cyc;
        bit v;
        do_reset();
        nvalid = 0;
        cyc = 0;
        while (locked !== 1'b1 && cyc < 1000) begin
            v = 1'($urandom_range(0, 1));
            step(good_hdr(), v);
            if (v) nvalid++;
            cyc++;
            total++;
            if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                data_out !== m_dout) begin
                bad++;
                $display("FAIL gaps c=%0d v=%b lk=%b/%b dv=%b/%b dout=%h/%h",
                         cyc, v, locked, m_locked, data_out_valid, m_dov,
                         data_out, m_dout);
            end
        end
        total++;
        if (nvalid != 64 || locked !== 1'b1) begin
            bad++;
            $display("FAIL gaps_count valid_words=%0d lk=%b want 64 1", nvalid, locked);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 74; i++) step(good_hdr(), 1'b1);
        data_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({locked, slip, data_out_valid} !== 3'b000 ||
            bad_hdr_cnt !== 16'd0 || data_out !== 66'd0) begin
            bad++;
            $display("FAIL async_reset lk=%b dv=%b dout=%h want 0",
                     locked, data_out_valid, data_out);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            step(good_hdr(), 1'b1);
            total++;
            if ({locked, slip, data_out_valid} !== {m_locked, m_slip, m_dov} ||
                data_out !== m_dout) begin
                bad++;
                $display("FAIL relock i=%0d lk=%b/%b dv=%b/%b",
                         i, locked, m_locked, data_out_valid, m_dov);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        data_in = '0;
        data_in_valid = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_acquire();
        test_slip_hunt();
        test_window();
        test_lose_lock();
        test_gaps();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_block_sync.md
Name: rx_block_sync

Overview:
- 64b/66b block-lock stage directly upstream of the RX descrambler. Sits between the RX gearbox and the descrambler.
- Checks the 2-bit sync header of every 66-bit word from the gearbox. Issues bitslip requests to the gearbox until header alignment is found.
- Declares lock after a run of valid headers. Drops lock when too many headers in a window are invalid.
- Forwards the registered word with a qualified enable to the descrambler.

Parameters:
- RX_DATA_WIDTH, 64, payload width; the word is RX_DATA_WIDTH+2 bits including the header.
- LOCK_COUNT, 64, consecutive valid headers needed to enter LOCKED.
- WINDOW, 1024, monitoring window length in LOCKED, counted in valid words.
- BAD_LIMIT, 16, invalid headers within one window that force loss of lock.
- SLIP_WAIT, 32, valid words ignored after a slip while the gearbox realigns.

Ports:
- clk  in  1  RX word clock.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  RX_DATA_WIDTH+2  gearbox word, indexed [0:RX_DATA_WIDTH+1]; header is [0:1], payload is [2:RX_DATA_WIDTH+1].
- data_in_valid  in  1  data_in holds a new word this cycle.
- data_out  out  RX_DATA_WIDTH+2  registered copy of data_in, same bit order (feeds the descrambler data_in).
- data_out_valid  out  1  enable for the descrambler.
- slip  out  1  one-cycle bitslip request to the gearbox.
- locked  out  1  block lock status.
- bad_hdr_cnt  out  16  saturating count of invalid headers seen while locked; cleared only by reset.

Behaviour:
- Reset: one clock domain (clk). rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0, all counters are 0 and the state is HUNT. Exit is synchronous to clk.
- Header valid: hdr_ok = (data_in[0:1]==2'b01) or (data_in[0:1]==2'b10). 00 and 11 are invalid.
- Only cycles with data_in_valid=1 advance counters or the FSM. Idle cycles hold all state. slip is 0 on idle cycles.
- Datapath, latency 1:
  - On data_in_valid, data_out <= data_in.
  - data_out_valid <= data_in_valid & locked_next, where locked_next is the lock state after this word's evaluation.
  - data_out holds its value when data_in_valid=0.
- FSM states: HUNT, SLIP_WAIT, LOCKED.
- HUNT:
  - hdr_ok: good_cnt++. If good_cnt==LOCK_COUNT-1 → LOCKED; locked<=1; clear good_cnt, win_cnt and bad_cnt.
  - !hdr_ok: slip<=1 for one cycle; good_cnt<=0; wait_cnt<=SLIP_WAIT-1; → SLIP_WAIT.
- SLIP_WAIT:
  - Headers are ignored and slip stays 0.
  - Each valid word decrements wait_cnt. When wait_cnt==0 on a valid word → HUNT with good_cnt=0.
- LOCKED:
  - Each valid word increments win_cnt. Each !hdr_ok word increments bad_cnt and bad_hdr_cnt (bad_hdr_cnt saturates at 16'hFFFF).
  - If !hdr_ok and bad_cnt==BAD_LIMIT-1: locked<=0, slip<=1, good_cnt<=0, wait_cnt<=SLIP_WAIT-1, → SLIP_WAIT. This check takes precedence over the window end.
  - Otherwise, if win_cnt==WINDOW-1: win_cnt<=0 and bad_cnt<=0. The invalid header on the last word of a window is discarded with the window.
- Loss of lock: the word that triggers it is not forwarded; data_out_valid=0 for that word.
- Lock acquisition: the LOCK_COUNT-th valid word is forwarded with data_out_valid=1.
- Counter widths are $clog2 of their limit plus 1. There is no wrap inside a state: every counter is cleared on state entry.
- slip is never asserted on two consecutive cycles. Minimum spacing between slips is SLIP_WAIT+1 valid words.

Test Plan:
- Reset, then 64 valid words with header 01 → locked=1 and data_out_valid=1 one cycle after the 64th word. slip never asserted.
- In HUNT, 10 good words then header 11 → one-cycle slip pulse. The next 32 valid words are ignored even if invalid. good_cnt restarts. 64 more good words → lock.
- Locked, 15 headers of 00 spread across one 1024-word window → stays locked; bad_hdr_cnt=15. Next window restarts bad_cnt at 0.
- Locked, 16 invalid headers within one window → on the 16th: locked=0, slip=1, data_out_valid=0 for that word. Then SLIP_WAIT, then HUNT.
- Random data_in_valid gaps (about 50% duty) during acquisition → lock occurs after exactly 64 valid words. data_out is stable across gaps.
- rst_n asserted mid-LOCKED and asynchronously (between edges) → outputs go to 0 immediately. After release, 64 good words are required to relock.
